// File: rtl/tub_scan_controller_if.sv
// Display-side bundle of the scan controller: display word, load strobe, masks
// and the per-digit outputs feeding the hex-to-segment decoder.
interface tub_scan_controller_if;
  logic [31:0] value;
  logic        load;
  logic [7:0]  blank_mask;
  logic [7:0]  blink_mask;
  logic        lz_blank;
  logic [3:0]  digit_data;
  logic [7:0]  digit_sel;
  logic        frame_start;

  modport master (
    output value, load, blank_mask, blink_mask, lz_blank,
    input  digit_data, digit_sel, frame_start
  );

  modport slave (
    input  value, load, blank_mask, blink_mask, lz_blank,
    output digit_data, digit_sel, frame_start
  );
endinterface

// File: rtl/tub_scan_controller.sv
// Eight-digit seven-segment scan controller with tear-free double buffering,
// leading-zero blanking, per-digit masking and per-digit blinking.
module tub_scan_controller #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  tub_scan_controller_if.slave  bus
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic [2:0]         idx;
  logic [31:0]        pending;
  logic               pend_v;
  logic [31:0]        shadow;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;
  logic               frame_start;

  logic               tick;
  logic               wrap;
  logic [7:0]         lz_dark;
  logic               upper_zero;
  logic               dark;

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx == 3'd7);

  // The shadow copy only changes at a frame wrap, so a frame never mixes two words.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= 3'd0;
      pending     <= 32'h0;
      pend_v      <= 1'b0;
      shadow      <= 32'h0;
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DIV_W'(1);
      frame_start <= wrap;
      if (tick) begin
        idx <= idx + 3'd1;
      end
      if (wrap && pend_v) begin
        shadow <= pending;
      end
      if (bus.load) begin
        pending <= bus.value;
        pend_v  <= 1'b1;
      end else if (wrap) begin
        pend_v  <= 1'b0;
      end
      if (wrap) begin
        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // Walk from the top digit down; a digit is lz-dark while everything from it up is zero.
  always_comb begin
    lz_dark    = 8'h00;
    upper_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      upper_zero = upper_zero & (shadow[4*i +: 4] == 4'h0);
      lz_dark[i] = bus.lz_blank & upper_zero;
    end
  end

  always_comb begin
    dark = bus.blank_mask[idx] | (bus.blink_mask[idx] & blink_ph) | lz_dark[idx];
  end

  assign bus.digit_data  = shadow[{idx, 2'b00} +: 4];
  assign bus.digit_sel   = dark ? 8'h00 : (8'h01 << idx);
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_tub_scan_controller.sv
// Scoreboard bench for tub_scan_controller: a timeline-based reference model
// queues per-cycle expectations and an independent monitor compares them.
module tb_tub_scan_controller;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  typedef struct {
    int          cyc;
    logic [3:0]  data;
    logic [7:0]  sel;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  tub_scan_controller_if bus ();

  tub_scan_controller #(
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          load_cyc[$];
  logic [31:0] load_val[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        checking = 1'b0;

  // Displayed word of frame f: the latest load accepted before the wrap edge that opens it.
  function automatic logic [31:0] shadow_for_frame(int f);
    logic [31:0] r;
    r = 32'h0;
    if (f > 0) begin
      for (int i = 0; i < load_cyc.size(); i++) begin
        if (load_cyc[i] <= FRAME * f - 2) r = load_val[i];
      end
    end
    return r;
  endfunction

  task automatic check_output(input string name, input int at, input logic [31:0] act,
                              input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, at, act, expv);
    end
  endtask

  // Build this cycle's expectation from the timeline, record loads, then advance one clock.
  task automatic apply_stimulus();
    exp_t        e;
    int          f;
    int          d;
    logic [31:0] sh;
    logic        ph;
    logic        lz;
    logic        dark;
    if (checking) begin
      f    = cyc / FRAME;
      d    = (cyc / SD) % 8;
      sh   = shadow_for_frame(f);
      ph   = ((f / BF) % 2) == 1;
      lz   = bus.lz_blank && (d >= 1) && ((sh >> (4 * d)) == 32'h0);
      dark = bus.blank_mask[d] || (bus.blink_mask[d] && ph) || lz;
      e.cyc  = cyc;
      e.data = 4'((sh >> (4 * d)) & 32'hF);
      e.sel  = dark ? 8'h00 : 8'(1 << d);
      e.fs   = (cyc > 0) && (cyc % FRAME == 0);
      exp_q.push_back(e);
    end
    if (!rst && bus.load) begin
      load_cyc.push_back(cyc);
      load_val.push_back(bus.value);
    end
    @(posedge clk);
    if (rst) begin
      cyc = 0;
      load_cyc.delete();
      load_val.delete();
      checking = 1'b1;
    end else begin
      cyc++;
    end
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) apply_stimulus();
  endtask

  task automatic load_once(input logic [31:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    apply_stimulus();
    bus.load  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output("digit_data",  e.cyc, 32'(bus.digit_data),  32'(e.data));
      check_output("digit_sel",   e.cyc, 32'(bus.digit_sel),   32'(e.sel));
      check_output("frame_start", e.cyc, 32'(bus.frame_start), 32'(e.fs));
    end
  end

  initial begin
    rst            = 1'b1;
    bus.value      = 32'h0;
    bus.load       = 1'b0;
    bus.blank_mask = 8'h00;
    bus.blink_mask = 8'h00;
    bus.lz_blank   = 1'b0;
    @(negedge clk);
    repeat (3) apply_stimulus();
    rst = 1'b0;

    $display("[TB] reset and scan order");
    load_once(32'h76543210);
    run_to(FRAME + 8);

    $display("[TB] tear-free load");
    load_once(32'hAAAAAAAA);
    run_to(2 * FRAME + 3 * SD);
    load_once(32'h12345678);

    $display("[TB] load on frame wrap");
    run_to(3 * FRAME + 5);
    load_once(32'h11111111);
    run_to(4 * FRAME - 1);
    load_once(32'h22222222);

    $display("[TB] leading-zero blanking");
    run_to(5 * FRAME + 2);
    load_once(32'h00000F03);
    run_to(6 * FRAME);
    bus.lz_blank = 1'b1;
    run_to(6 * FRAME + 10);
    load_once(32'h00000000);

    $display("[TB] blink and blank");
    run_to(8 * FRAME);
    bus.lz_blank   = 1'b0;
    bus.blink_mask = 8'h01;
    bus.blank_mask = 8'h80;
    load_once(32'h89ABCDEF);
    run_to(14 * FRAME);

    $display("[TB] randomized traffic");
    while (cyc < 21 * FRAME) begin
      if ($urandom_range(7) == 0) begin
        bus.value = $urandom;
        bus.load  = 1'b1;
      end else begin
        bus.load  = 1'b0;
      end
      if ($urandom_range(15) == 0) bus.blank_mask = 8'($urandom);
      if ($urandom_range(15) == 0) bus.blink_mask = 8'($urandom);
      if ($urandom_range(15) == 0) bus.lz_blank   = 1'($urandom);
      apply_stimulus();
    end
    bus.load       = 1'b0;
    bus.blank_mask = 8'h00;
    bus.blink_mask = 8'hFF;
    bus.lz_blank   = 1'b0;

    $display("[TB] reset mid-operation");
    run_to(22 * FRAME + 2);
    load_once(32'hDEADBEEF);
    run_to(22 * FRAME + 5 * SD + 1);
    rst = 1'b1;
    apply_stimulus();
    rst = 1'b0;
    run_to(3 * FRAME);

    @(posedge clk);
    #1;
    check_output("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tub_scan_controller.md
# tub_scan_controller

Time-multiplexed scan controller for the 8-digit seven-segment display, sitting directly upstream of the per-digit hex-to-segment decoder. It takes a 32-bit display word from the CPU/MMIO side, buffers it so the display never tears mid-frame, and cycles through the eight digits one at a time. For each digit it emits the 4-bit nibble for the decoder and the matching one-hot digit select, with optional leading-zero blanking, per-digit masking and per-digit blinking.

## Interface

- `SCAN_DIV`, 100000: clock cycles each digit stays selected; must be ≥ 2.
- `BLINK_FRAMES`, 32: full frames (8 digits each) per blink half-period; must be ≥ 1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `value`  in  32  display word; digit i shows `value[4i+3:4i]`; digit 0 is rightmost.
- `load`  in  1  one-cycle strobe that captures `value` into the pending register.
- `blank_mask`  in  8  bit i = 1 forces digit i dark; sampled live.
- `blink_mask`  in  8  bit i = 1 makes digit i dark during the blink-off phase; sampled live.
- `lz_blank`  in  1  1 = blank leading zero digits; digit 0 is never lz-blanked; sampled live.
- `digit_data`  out  4  nibble of the currently selected digit; drives the decoder input.
- `digit_sel`  out  8  one-hot, active-high digit enable; all zero when the current digit is dark.
- `frame_start`  out  1  one-cycle pulse on the cycle digit index 0 becomes current.

## Operation

- **Divider.**
  - `div_cnt` counts 0..SCAN_DIV-1 and wraps.
  - `tick` = (`div_cnt` == SCAN_DIV-1).
- **Digit index.**
  - `idx` is 3 bits and advances by 1 on every tick.
  - It wraps 7 → 0 naturally.
- **Buffering.**
  - `load` writes `value` into `pending` and sets `pend_v`. The last load wins.
  - On a tick with `idx` == 7 (the frame wrap), if `pend_v` is set: `shadow` ← `pending` and `pend_v` is cleared.
  - If `load` and the frame wrap occur on the same edge:
    - `shadow` takes the old `pending`, but only if `pend_v` was set.
    - `pending` takes the new `value`.
    - `pend_v` ends at 1.
- **Blink.**
  - `blink_cnt` counts frame wraps 0..BLINK_FRAMES-1.
  - On the wrap where it reaches its terminal count, it returns to 0 and `blink_ph` toggles.
  - `blink_ph` = 1 is the off phase.
- **Leading-zero computation.** Uses `shadow` only.
  - Digit i (i ≥ 1) is lz-dark when `lz_blank` = 1 and every nibble from i through 7 is zero.
- **Output decode.** Combinational from the registered state (`idx`, `shadow`, `blink_ph`) and the live mask inputs.
  - `digit_data` = `shadow[4*idx+3 : 4*idx]`.
  - The digit is dark if any of these holds: `blank_mask[idx]`; (`blink_mask[idx]` and `blink_ph`); lz-dark(idx).
  - `digit_sel` = dark ? 8'h00 : (8'h01 << `idx`).
  - `digit_data` is still driven with the nibble while the digit is dark.
- **frame_start.** Registered; equals 1 for exactly the cycle after the edge where `idx` goes 7 → 0.

## Timing

- **Reset** (synchronous, any cycle, including mid-frame and mid-blink): clears `div_cnt`, `idx`, `pending`, `pend_v`, `shadow`, `blink_cnt`, `blink_ph` and `frame_start`.
- **Output values during reset and the first cycle after it:**
  - `digit_data` = 0.
  - `digit_sel` = 8'h01, unless masked by `blank_mask[0]`.
  - `frame_start` = 0.
- **Digit advance.**
  - Each digit is selected for exactly SCAN_DIV cycles.
  - A full frame is 8·SCAN_DIV cycles.
  - The first frame after reset is also 8·SCAN_DIV cycles long.
- **Load latency.**
  - A load becomes visible at the next frame wrap, never mid-frame.
  - Worst case is 8·SCAN_DIV cycles after the load.
- **Blink.** Each phase lasts BLINK_FRAMES·8·SCAN_DIV cycles. The first toggle after reset happens at frame wrap number BLINK_FRAMES.
- **Mask inputs.**
  - `blank_mask`, `blink_mask` and `lz_blank` act combinationally on the current digit.
  - The upstream register owns their glitch-freedom.
- **frame_start period.**
  - The first pulse occurs 8·SCAN_DIV cycles after reset deasserts.
  - The pulse then repeats with period 8·SCAN_DIV.

## Test plan

All scenarios use SCAN_DIV = 4 and BLINK_FRAMES = 2.

1. **Reset and scan order.**
   - Stimulus: assert `rst` 3 cycles, then release, with `value` = 0x76543210 and load on the first cycle.
   - Required response, first frame: `digit_data` = 0 throughout; `digit_sel` walks 01, 02, …, 80, 4 cycles each.
   - Required response, second frame: `digit_data` = 0, 1, …, 7 in step with `digit_sel`.
2. **Tear-free load.**
   - Stimulus: a load of 0x12345678 lands while `idx` = 3 (shadow at 0xAAAAAAAA).
   - Required response: digits 3..7 of the current frame show A; the next frame shows 8, 7, 6, …, 1.
3. **Load on frame wrap.**
   - Stimulus: pending 0x11111111 is valid, and a load of 0x22222222 arrives on the wrap edge.
   - Required response: the next frame shows all 1s; the following frame shows all 2s.
4. **Leading-zero blanking.**
   - Stimulus: `value` = 0x00000F03 with `lz_blank` = 1.
   - Required response: `digit_sel` active only for idx 0, 1, 2, with data 3, 0, F.
   - Additional: `value` = 0 gives only digit 0 lit, showing 0.
5. **Blink and blank.**
   - Stimulus: `blink_mask` = 0x01 and `blank_mask` = 0x80.
   - Required response: digit 0 is lit for 2 frames, then dark for 2 frames, repeating; digit 7 is never lit.
6. **Reset mid-operation.**
   - Stimulus: assert `rst` at `idx` = 5 with `blink_ph` = 1 and pending valid.
   - Required response: the next cycle shows `digit_sel` = 01, `digit_data` = 0, no `frame_start`; the old pending value is never displayed.
